// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI slave.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_state_t;

  // CPHA=0 samples mosi on the leading sclk edge, CPHA=1 on the trailing one.
  function automatic logic sample_on_leading(input logic cpha);
    return !cpha;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for an asynchronous input with single-cycle
// rise/fall pulses derived from the synchronised copy.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave with configurable width, mode and bit order; oversamples the
// SPI pins in the clk domain and exposes valid/ready rx/tx word streams.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int unsigned      CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s, lead, trail, sample_ev, shift_ev, load;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst_n(rst), .d_i(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst_n(rst), .d_i(cs), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync_q <= '0;
    else      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign lead      = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail     = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_ev = sample_on_leading(CPHA != 0) ? lead  : trail;
  assign shift_ev  = sample_on_leading(CPHA != 0) ? trail : lead;

  spi_state_t        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d, rx_word, tx_next;
  logic              rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic              rx_overrun_q, rx_overrun_d, tx_underrun_q, tx_underrun_d;
  logic              frame_abort_q, frame_abort_d;

  assign rx_word = (MSB_FIRST != 0) ? {rx_shift_q[DATA_W-2:0], mosi_s}
                                    : {mosi_s, rx_shift_q[DATA_W-1:1]};
  assign tx_next = (MSB_FIRST != 0) ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                    : {1'b0, tx_shift_q[DATA_W-1:1]};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    tx_ready_d    = 1'b0;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    load          = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d       = IDLE;
          bit_cnt_d     = '0;
          rx_shift_d    = '0;
          tx_shift_d    = '0;
          frame_abort_d = (bit_cnt_q != '0);
        end else begin
          // The shift edge that falls on a word boundary would skip the
          // freshly loaded first bit, so it is suppressed while bit_cnt==0.
          if (shift_ev && bit_cnt_q != '0) tx_shift_d = tx_next;
          if (sample_ev) begin
            if (bit_cnt_q == LAST) begin
              bit_cnt_d  = '0;
              rx_shift_d = '0;
              load       = 1'b1;
              if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
              end else begin
                rx_overrun_d = 1'b1;
              end
            end else begin
              bit_cnt_d  = bit_cnt_q + CNT_W'(1);
              rx_shift_d = rx_word;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (tx_valid) begin
        tx_shift_d = tx_data;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d    = '0;
        tx_underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign miso        = busy & ((MSB_FIRST != 0) ? tx_shift_q[DATA_W-1] : tx_shift_q[0]);
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench: five slaves (modes 0-3 MSB-first, mode 0 LSB-first) driven by one bit-banged master.
module tb_spi_slave_param;

  localparam int N    = 5;
  localparam int HALF = 40;
  localparam logic [4:0] CPOL_V = 5'b01100;
  localparam logic [4:0] CPHA_V = 5'b01010;
  localparam logic [4:0] MSB_V  = 5'b01111;

  logic       clk = 1'b0;
  logic       rst, sclk = 1'b0, mosi = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0;
  logic [4:0] cs_v = '1;
  logic [7:0] tx_data = 8'h00;
  logic [4:0] miso_w, tx_ready_w, rx_valid_w, busy_w, ovr_w, und_w, abt_w;
  logic [7:0] rx_data_w [N];

  int checks = 0;
  int fails  = 0;
  int txr_cnt [N] = '{default: 0};
  int ovr_cnt [N] = '{default: 0};
  int und_cnt [N] = '{default: 0};
  int abt_cnt [N] = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_slave_param #(
      .DATA_W(8), .CPOL(CPOL_V[g] ? 1 : 0), .CPHA(CPHA_V[g] ? 1 : 0),
      .MSB_FIRST(MSB_V[g] ? 1 : 0), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs_v[g]), .mosi(mosi), .miso(miso_w[g]),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_w[g]),
      .rx_data(rx_data_w[g]), .rx_valid(rx_valid_w[g]), .rx_ready(rx_ready),
      .busy(busy_w[g]), .rx_overrun(ovr_w[g]), .tx_underrun(und_w[g]),
      .frame_abort(abt_w[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      txr_cnt[i] <= txr_cnt[i] + int'(tx_ready_w[i]);
      ovr_cnt[i] <= ovr_cnt[i] + int'(ovr_w[i]);
      und_cnt[i] <= und_cnt[i] + int'(und_w[i]);
      abt_cnt[i] <= abt_cnt[i] + int'(abt_w[i]);
    end
  end

  function automatic logic [31:0] outv(input int i);
    return {17'd0, miso_w[i], tx_ready_w[i], rx_valid_w[i], busy_w[i],
            ovr_w[i], und_w[i], abt_w[i], rx_data_w[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Master side of one word (or nbits of it); got is reassembled in word bit order.
  task automatic xfer(input int idx, input logic [7:0] w, input int nbits,
                      output logic [7:0] got, output int lat);
    logic b, rb;
    got = '0;
    lat = 0;
    for (int i = 0; i < nbits; i++) begin
      b = MSB_V[idx] ? w[7-i] : w[i];
      if (!CPHA_V[idx]) begin
        mosi = b; #HALF;
        sclk = ~CPOL_V[idx]; rb = miso_w[idx];
      end else begin
        sclk = ~CPOL_V[idx]; mosi = b; #HALF;
        sclk = CPOL_V[idx]; rb = miso_w[idx];
      end
      if (i == 7) begin
        for (int k = 1; k <= 4; k++) begin
          @(posedge clk); #1;
          if (lat == 0 && rx_valid_w[idx]) lat = k;
        end
        #4;
      end else begin
        #HALF;
      end
      if (!CPHA_V[idx]) sclk = CPOL_V[idx];
      if (MSB_V[idx]) got[7-i] = rb;
      else            got[i]   = rb;
    end
  endtask

  task automatic cs_low(input int idx);
    @(negedge clk);
    sclk = CPOL_V[idx];
    #HALF;
    cs_v[idx] = 1'b0;
    #(2*HALF);
  endtask

  task automatic cs_high(input int idx);
    cs_v[idx] = 1'b1;
    #(2*HALF);
  endtask

  task automatic rx_accept();
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
  endtask

  task automatic mode_frame(input int idx);
    logic [7:0] got;
    int lat, t0, u0, a0;
    tx_data = 8'hA5; tx_valid = 1'b1; rx_ready = 1'b0;
    t0 = txr_cnt[idx]; u0 = und_cnt[idx]; a0 = abt_cnt[idx];
    cs_low(idx);
    check($sformatf("m%0d_busy", idx), 32'(busy_w[idx]), 32'd1);
    check($sformatf("m%0d_txready_csfall", idx), 32'(txr_cnt[idx] - t0), 32'd1);
    xfer(idx, 8'h3C, 8, got, lat);
    check($sformatf("m%0d_rx_valid", idx), 32'(rx_valid_w[idx]), 32'd1);
    check($sformatf("m%0d_rx_data", idx), 32'(rx_data_w[idx]), 32'h3C);
    check($sformatf("m%0d_miso_word", idx), 32'(got), 32'hA5);
    check($sformatf("m%0d_latency_ok", idx), 32'(lat >= 1 && lat <= 4), 32'd1);
    cs_high(idx);
    check($sformatf("m%0d_busy_end", idx), 32'(busy_w[idx]), 32'd0);
    check($sformatf("m%0d_no_abort", idx), 32'(abt_cnt[idx] - a0), 32'd0);
    check($sformatf("m%0d_no_underrun", idx), 32'(und_cnt[idx] - u0), 32'd0);
    rx_accept();
    check($sformatf("m%0d_rx_cleared", idx), 32'(rx_valid_w[idx]), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    int lat, o0, u0, a0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("reset_outputs_%0d", i), outv(i), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int m = 0; m < N; m++) mode_frame(m);

    // Two words in one frame with rx_ready low: second word must be dropped.
    tx_data = 8'hA5; tx_valid = 1'b1;
    o0 = ovr_cnt[0];
    cs_low(0);
    xfer(0, 8'h11, 8, got, lat);
    xfer(0, 8'h22, 8, got, lat);
    check("b2b_rx_data", 32'(rx_data_w[0]), 32'h11);
    check("b2b_rx_valid", 32'(rx_valid_w[0]), 32'd1);
    check("b2b_overrun", 32'(ovr_cnt[0] - o0), 32'd1);
    cs_high(0);
    rx_accept();

    // No tx word available: zeros on miso, underrun at cs fall and at word end.
    tx_valid = 1'b0;
    u0 = und_cnt[0];
    cs_low(0);
    check("und_at_csfall", 32'(und_cnt[0] - u0), 32'd1);
    xfer(0, 8'h5A, 8, got, lat);
    check("und_miso_zero", 32'(got), 32'h00);
    check("und_rx_data", 32'(rx_data_w[0]), 32'h5A);
    cs_high(0);
    check("und_total", 32'(und_cnt[0] - u0), 32'd2);
    rx_accept();

    // Partial word aborted, then a clean frame.
    tx_valid = 1'b1;
    a0 = abt_cnt[0];
    cs_low(0);
    xfer(0, 8'hFF, 5, got, lat);
    cs_high(0);
    check("abort_pulse", 32'(abt_cnt[0] - a0), 32'd1);
    check("abort_no_rx_valid", 32'(rx_valid_w[0]), 32'd0);
    cs_low(0);
    xfer(0, 8'hF0, 8, got, lat);
    check("after_abort_rx_data", 32'(rx_data_w[0]), 32'hF0);
    check("after_abort_rx_valid", 32'(rx_valid_w[0]), 32'd1);
    check("after_abort_miso", 32'(got), 32'hA5);
    cs_high(0);
    check("after_abort_no_abort", 32'(abt_cnt[0] - a0), 32'd1);
    rx_accept();

    // Reset in the middle of a frame; cs still low at release must not start a frame.
    cs_low(0);
    xfer(0, 8'hC3, 3, got, lat);
    check("pre_reset_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b0;
    #1;
    check("midreset_outputs", outv(0), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #(4*HALF);
    check("post_release_idle", 32'(busy_w[0]), 32'd0);
    cs_high(0);
    cs_low(0);
    xfer(0, 8'h81, 8, got, lat);
    check("post_reset_rx_data", 32'(rx_data_w[0]), 32'h81);
    check("post_reset_rx_valid", 32'(rx_valid_w[0]), 32'd1);
    check("post_reset_miso", 32'(got), 32'hA5);
    cs_high(0);
    rx_accept();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
